pc_fetch_ctrl: RTL and testbench

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

---
 rtl/pc_fetch_pkg.sv | 9 +
 rtl/pc_fetch_if.sv | 14 +
 rtl/next_pc_sel.sv | 22 ++
 rtl/pc_fetch_ctrl.sv | 62 ++++++
 tb/tb_pc_fetch_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared fetch FSM states, jump_ctrl encodings and PC step
package pc_fetch_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, MISS, REDIR} state_t;
  localparam logic [1:0] JC_SEQ = 2'b00;
  localparam logic [1:0] JC_JAL = 2'b01;
  localparam logic [1:0] JC_JR  = 2'b10;
  localparam logic [1:0] JC_BR  = 2'b11;
  localparam int PC_INC = 4;
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: redirect inputs, I-cache handshake and IF/ID outputs of the fetch controller
interface pc_fetch_if #(parameter int bit_size = 32);
  logic stall, branch, ic_ready, ic_req, if_valid, flush;
  logic [1:0] jump_ctrl;
  logic [bit_size-1:0] jump_target, jr_target, branch_target, ic_addr, pc;
  modport master (
    input  stall, jump_ctrl, branch, jump_target, jr_target, branch_target, ic_ready,
    output ic_req, ic_addr, pc, if_valid, flush
  );
  modport slave (
    output stall, jump_ctrl, branch, jump_target, jr_target, branch_target, ic_ready,
    input  ic_req, ic_addr, pc, if_valid, flush
  );
endinterface

// File: rtl/next_pc_sel.sv
// next_pc_sel: picks the redirect target (word aligned) or the sequential pc+4
module next_pc_sel
  import pc_fetch_pkg::*;
#(
  parameter int bit_size = 32
) (
  input  logic [bit_size-1:0] pc,
  input  logic [1:0]          jump_ctrl,
  input  logic                branch,
  input  logic [bit_size-1:0] jump_target,
  input  logic [bit_size-1:0] jr_target,
  input  logic [bit_size-1:0] branch_target,
  output logic [bit_size-1:0] next_pc,
  output logic                redirect
);
  logic [bit_size-1:0] target;
  always_comb begin
    redirect = (jump_ctrl == JC_JAL) || (jump_ctrl == JC_JR) || (jump_ctrl == JC_BR && branch);
    target = jump_ctrl == JC_JAL ? jump_target : jump_ctrl == JC_JR ? jr_target : branch_target;
    next_pc = redirect ? {target[bit_size-1:2], 2'b00} : pc + bit_size'(PC_INC);
  end
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC register and fetch FSM handling I-cache misses and pipeline redirects
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int                  bit_size = 32,
  parameter logic [bit_size-1:0] RESET_PC = '0
) (
  input logic      clk,
  input logic      rst,
  pc_fetch_if.master bus
);
  state_t state;
  logic pending, redirect;
  logic [bit_size-1:0] pending_target, next_pc;
  next_pc_sel #(.bit_size(bit_size)) u_sel (
    .pc(bus.pc), .jump_ctrl(bus.jump_ctrl), .branch(bus.branch),
    .jump_target(bus.jump_target), .jr_target(bus.jr_target), .branch_target(bus.branch_target),
    .next_pc(next_pc), .redirect(redirect)
  );
  assign bus.ic_addr = bus.pc;
  // a pending redirect marks the returning fill as stale; flush always beats delivery
  always_comb begin
    bus.flush = redirect && state != BOOT;
    bus.if_valid = state != BOOT && !pending && bus.ic_ready && !bus.stall && !bus.flush;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= BOOT;
      bus.pc <= RESET_PC;
      bus.ic_req <= 1'b0;
      pending <= 1'b0;
      pending_target <= '0;
    end else begin
      bus.ic_req <= 1'b1;
      case (state)
        BOOT: state <= FETCH;
        FETCH: begin
          if (redirect) bus.pc <= next_pc;
          else if (!bus.stall && bus.ic_ready) bus.pc <= next_pc;
          else if (!bus.stall) state <= MISS;
        end
        MISS: begin
          if (redirect && !bus.ic_ready) begin
            pending_target <= next_pc;
            pending <= 1'b1;
            state <= REDIR;
          end else if (bus.ic_ready) begin
            state <= FETCH;
            if (redirect || !bus.stall) bus.pc <= next_pc;
          end
        end
        REDIR: begin
          if (bus.ic_ready) begin
            bus.pc <= redirect ? next_pc : pending_target;
            pending <= 1'b0;
            state <= FETCH;
          end else if (redirect) pending_target <= next_pc;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed scenario tests for the fetch controller
module tb_pc_fetch_ctrl;
  import pc_fetch_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int compared = 0;
  int mismatched = 0;
  pc_fetch_if #(.bit_size(32)) bus();
  pc_fetch_ctrl #(.bit_size(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [1:0] jc, input logic br, input logic rdy, input logic stl);
    bus.jump_ctrl = jc;
    bus.branch = br;
    bus.ic_ready = rdy;
    bus.stall = stl;
    #1;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    bus.jump_target = a;
    set_in(JC_JAL, 1'b0, 1'b1, 1'b0);
    tick();
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.jump_target = '0; bus.jr_target = '0; bus.branch_target = '0;
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b0);
    tick();
    tick();
    compared++; if (bus.pc !== 32'h0) begin mismatched++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
    compared++; if (bus.ic_req !== 1'b0) begin mismatched++; $display("FAIL reset_ic_req: got %b want 0", bus.ic_req); end
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
    compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL reset_flush: got %b want 0", bus.flush); end
    compared++; if (dut.state !== BOOT) begin mismatched++; $display("FAIL reset_state: got %0d want %0d", dut.state, BOOT); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [5] = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    logic        exp_v  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rst = 1'b1;
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      compared++; if (bus.pc !== exp_pc[i]) begin mismatched++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, exp_pc[i]); end
      compared++; if (bus.if_valid !== exp_v[i]) begin mismatched++; $display("FAIL seq_if_valid[%0d]: got %b want %b", i, bus.if_valid, exp_v[i]); end
      compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL seq_flush[%0d]: got %b want 0", i, bus.flush); end
      compared++; if (bus.ic_addr !== exp_pc[i]) begin mismatched++; $display("FAIL seq_ic_addr[%0d]: got %h want %h", i, bus.ic_addr, exp_pc[i]); end
      tick();
    end
  endtask

  task automatic test_jump();
    compared++; if (bus.pc !== 32'h10) begin mismatched++; $display("FAIL jump_start_pc: got %h want %h", bus.pc, 32'h10); end
    bus.jump_target = 32'h200;
    set_in(JC_JAL, 1'b0, 1'b1, 1'b0);
    compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("FAIL jump_flush: got %b want 1", bus.flush); end
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("FAIL jump_if_valid: got %b want 0", bus.if_valid); end
    tick();
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b0);
    compared++; if (bus.pc !== 32'h200) begin mismatched++; $display("FAIL jump_pc: got %h want %h", bus.pc, 32'h200); end
    compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL jump_flush_end: got %b want 0", bus.flush); end
    compared++; if (bus.if_valid !== 1'b1) begin mismatched++; $display("FAIL jump_if_valid_after: got %b want 1", bus.if_valid); end
  endtask

  task automatic test_branch_jr();
    goto_pc(32'h20);
    bus.branch_target = 32'h500;
    set_in(JC_BR, 1'b0, 1'b1, 1'b0);
    compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL bnt_flush: got %b want 0", bus.flush); end
    compared++; if (bus.if_valid !== 1'b1) begin mismatched++; $display("FAIL bnt_if_valid: got %b want 1", bus.if_valid); end
    tick();
    compared++; if (bus.pc !== 32'h24) begin mismatched++; $display("FAIL bnt_pc: got %h want %h", bus.pc, 32'h24); end
    bus.jr_target = 32'h103;
    set_in(JC_JR, 1'b0, 1'b1, 1'b0);
    compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("FAIL jr_flush: got %b want 1", bus.flush); end
    tick();
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b0);
    compared++; if (bus.pc !== 32'h100) begin mismatched++; $display("FAIL jr_pc: got %h want %h", bus.pc, 32'h100); end
  endtask

  task automatic test_stall();
    goto_pc(32'h30);
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      compared++; if (bus.pc !== 32'h30) begin mismatched++; $display("FAIL stall_pc[%0d]: got %h want %h", i, bus.pc, 32'h30); end
      compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("FAIL stall_if_valid[%0d]: got %b want 0", i, bus.if_valid); end
      tick();
    end
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b0);
    compared++; if (bus.if_valid !== 1'b1) begin mismatched++; $display("FAIL stall_release_valid: got %b want 1", bus.if_valid); end
    tick();
    compared++; if (bus.pc !== 32'h34) begin mismatched++; $display("FAIL stall_release_pc: got %h want %h", bus.pc, 32'h34); end
    bus.jump_target = 32'h44;
    set_in(JC_JAL, 1'b0, 1'b1, 1'b1);
    compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("FAIL stall_redir_flush: got %b want 1", bus.flush); end
    tick();
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b0);
    compared++; if (bus.pc !== 32'h44) begin mismatched++; $display("FAIL stall_redir_pc: got %h want %h", bus.pc, 32'h44); end
  endtask

  task automatic test_miss_redirect();
    goto_pc(32'h40);
    set_in(JC_SEQ, 1'b0, 1'b0, 1'b0);
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("FAIL miss_if_valid: got %b want 0", bus.if_valid); end
    tick();
    compared++; if (dut.state !== MISS) begin mismatched++; $display("FAIL miss_state: got %0d want %0d", dut.state, MISS); end
    bus.branch_target = 32'h80;
    set_in(JC_BR, 1'b1, 1'b0, 1'b0);
    compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("FAIL miss_br_flush: got %b want 1", bus.flush); end
    tick();
    set_in(JC_SEQ, 1'b0, 1'b0, 1'b0);
    compared++; if (dut.pending !== 1'b1) begin mismatched++; $display("FAIL miss_pending: got %b want 1", dut.pending); end
    for (int i = 0; i < 3; i++) begin
      compared++; if (bus.ic_addr !== 32'h40) begin mismatched++; $display("FAIL redir_hold_addr[%0d]: got %h want %h", i, bus.ic_addr, 32'h40); end
      compared++; if (bus.flush !== 1'b0) begin mismatched++; $display("FAIL redir_hold_flush[%0d]: got %b want 0", i, bus.flush); end
      tick();
    end
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b0);
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("FAIL redir_discard: got %b want 0", bus.if_valid); end
    tick();
    compared++; if (bus.pc !== 32'h80) begin mismatched++; $display("FAIL redir_pc: got %h want %h", bus.pc, 32'h80); end
    compared++; if (dut.pending !== 1'b0) begin mismatched++; $display("FAIL redir_pending_clr: got %b want 0", dut.pending); end
    compared++; if (bus.if_valid !== 1'b1) begin mismatched++; $display("FAIL redir_resume_valid: got %b want 1", bus.if_valid); end
  endtask

  task automatic test_redir_overwrite();
    set_in(JC_SEQ, 1'b0, 1'b0, 1'b0);
    tick();
    bus.jump_target = 32'h300;
    set_in(JC_JAL, 1'b0, 1'b0, 1'b0);
    tick();
    bus.jr_target = 32'h407;
    set_in(JC_JR, 1'b0, 1'b0, 1'b0);
    compared++; if (bus.flush !== 1'b1) begin mismatched++; $display("FAIL ovw_flush: got %b want 1", bus.flush); end
    tick();
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b0);
    tick();
    compared++; if (bus.pc !== 32'h404) begin mismatched++; $display("FAIL ovw_pc: got %h want %h", bus.pc, 32'h404); end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    compared++; if (bus.pc !== 32'hFFFF_FFFC) begin mismatched++; $display("FAIL wrap_top: got %h want %h", bus.pc, 32'hFFFF_FFFC); end
    tick();
    compared++; if (bus.pc !== 32'h0) begin mismatched++; $display("FAIL wrap_pc: got %h want %h", bus.pc, 32'h0); end
  endtask

  task automatic test_reset_mid_redir();
    goto_pc(32'h60);
    set_in(JC_SEQ, 1'b0, 1'b0, 1'b0);
    tick();
    bus.jump_target = 32'h700;
    set_in(JC_JAL, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(JC_SEQ, 1'b0, 1'b0, 1'b0);
    compared++; if (dut.state !== REDIR) begin mismatched++; $display("FAIL rr_state_redir: got %0d want %0d", dut.state, REDIR); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    compared++; if (dut.state !== BOOT) begin mismatched++; $display("FAIL rr_state_boot: got %0d want %0d", dut.state, BOOT); end
    compared++; if (bus.pc !== 32'h0) begin mismatched++; $display("FAIL rr_pc: got %h want %h", bus.pc, 32'h0); end
    compared++; if (dut.pending !== 1'b0) begin mismatched++; $display("FAIL rr_pending: got %b want 0", dut.pending); end
    set_in(JC_SEQ, 1'b0, 1'b1, 1'b0);
    compared++; if (bus.if_valid !== 1'b0) begin mismatched++; $display("FAIL rr_ignore_ready: got %b want 0", bus.if_valid); end
    tick();
    set_in(JC_SEQ, 1'b0, 1'b0, 1'b0);
    compared++; if (bus.pc !== 32'h0) begin mismatched++; $display("FAIL rr_fetch_pc: got %h want %h", bus.pc, 32'h0); end
    compared++; if (bus.ic_req !== 1'b1) begin mismatched++; $display("FAIL rr_ic_req: got %b want 1", bus.ic_req); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jump();
    test_branch_jr();
    test_stall();
    test_miss_redirect();
    test_redir_overwrite();
    test_wrap();
    test_reset_mid_redir();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
